// File: rtl/rs_ldst_queue.sv
`default_nettype none
// ============================================================================
// Module   : rs_ldst_queue
// Purpose  : Age-ordered circular load/store reservation station. Dual dispatch,
//            operand capture from forwarding buses, in-order issue to the LSU.
// Option   : RS_LDST_DISPATCH_BYPASS_EN - capture forwards on dispatching operands
// Revision : 1.0 - initial release
// ============================================================================
module rs_ldst_queue #(
    parameter int ENT_NUM  = 8,
    parameter int ENT_SEL  = 3,
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int RRF_SEL  = 6,
    parameter int FWD_NUM  = 5
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          we_1_i,
    input  logic                          we_2_i,
    input  logic [ADDR_LEN-1:0]           write_pc_1_i,
    input  logic [ADDR_LEN-1:0]           write_pc_2_i,
    input  logic [DATA_LEN-1:0]           write_src_op_1_1_i,
    input  logic [DATA_LEN-1:0]           write_src_op_1_2_i,
    input  logic [DATA_LEN-1:0]           write_src_op_2_1_i,
    input  logic [DATA_LEN-1:0]           write_src_op_2_2_i,
    input  logic                          write_valid_1_1_i,
    input  logic                          write_valid_1_2_i,
    input  logic                          write_valid_2_1_i,
    input  logic                          write_valid_2_2_i,
    input  logic [DATA_LEN-1:0]           write_imm_1_i,
    input  logic [DATA_LEN-1:0]           write_imm_2_i,
    input  logic [RRF_SEL-1:0]            write_rrf_tag_1_i,
    input  logic [RRF_SEL-1:0]            write_rrf_tag_2_i,
    input  logic                          write_dst_val_1_i,
    input  logic                          write_dst_val_2_i,
    input  logic [FWD_NUM*DATA_LEN-1:0]   fwd_result_i,
    input  logic [FWD_NUM*RRF_SEL-1:0]    fwd_dst_i,
    input  logic [FWD_NUM-1:0]            fwd_valid_i,
    input  logic                          issue_ready_i,
    output logic                          alloc_ok_o,
    output logic [ENT_SEL:0]              count_o,
    output logic                          issue_valid_o,
    output logic [DATA_LEN-1:0]           exe_src_op_1_o,
    output logic [DATA_LEN-1:0]           exe_src_op_2_o,
    output logic [ADDR_LEN-1:0]           exe_pc_o,
    output logic [DATA_LEN-1:0]           exe_imm_o,
    output logic [RRF_SEL-1:0]            exe_rrf_tag_o,
    output logic                          exe_dst_val_o,
    output logic [ENT_NUM-1:0]            ready_vector_o
);

    localparam logic [ENT_SEL:0] c_ALLOC_LIMIT = (ENT_SEL+1)'(ENT_NUM - 2);

    logic [ENT_SEL-1:0]  r_head;
    logic [ENT_SEL-1:0]  r_tail;
    logic [ENT_SEL:0]    r_count;
    logic [ENT_NUM-1:0]  r_busy;
    logic [ENT_NUM-1:0]  r_v1;
    logic [ENT_NUM-1:0]  r_v2;
    logic [ENT_NUM-1:0]  r_dst_val;
    logic [DATA_LEN-1:0] r_op1 [ENT_NUM];
    logic [DATA_LEN-1:0] r_op2 [ENT_NUM];
    logic [ADDR_LEN-1:0] r_pc  [ENT_NUM];
    logic [DATA_LEN-1:0] r_imm [ENT_NUM];
    logic [RRF_SEL-1:0]  r_tag [ENT_NUM];

    logic                w_alloc_ok;
    logic                w_we1;
    logic                w_we2;
    logic [1:0]          w_n_disp;
    logic                w_fire;
    logic [ENT_SEL-1:0]  w_idx2;
    logic [ENT_NUM-1:0]  w_cap1;
    logic [ENT_NUM-1:0]  w_cap2;
    logic [DATA_LEN-1:0] w_cap1_data [ENT_NUM];
    logic [DATA_LEN-1:0] w_cap2_data [ENT_NUM];
    logic [DATA_LEN-1:0] w_in_op  [4];
    logic [3:0]          w_in_v;
    logic [DATA_LEN-1:0] w_new_op [4];
    logic [3:0]          w_new_v;

    // Returns {hit, data}; the lowest-indexed matching bus wins.
    function automatic logic [DATA_LEN:0] fwd_lookup(
        input logic [RRF_SEL-1:0]          tag,
        input logic [FWD_NUM-1:0]          fvalid,
        input logic [FWD_NUM*RRF_SEL-1:0]  fdst,
        input logic [FWD_NUM*DATA_LEN-1:0] fres
    );
        logic [DATA_LEN:0] res;
        res = '0;
        for (int k = FWD_NUM - 1; k >= 0; k--) begin
            if (fvalid[k] && (fdst[k*RRF_SEL +: RRF_SEL] == tag))
                res = {1'b1, fres[k*DATA_LEN +: DATA_LEN]};
        end
        return res;
    endfunction

    assign w_alloc_ok = (r_count <= c_ALLOC_LIMIT);
    assign w_we1      = we_1_i & w_alloc_ok;
    assign w_we2      = we_2_i & w_alloc_ok;
    assign w_n_disp   = {1'b0, w_we1} + {1'b0, w_we2};
    assign w_idx2     = w_we1 ? (r_tail + ENT_SEL'(1)) : r_tail;

    assign issue_valid_o = r_busy[r_head] & r_v1[r_head] & r_v2[r_head];
    assign w_fire        = issue_valid_o & issue_ready_i;

    assign alloc_ok_o     = w_alloc_ok;
    assign count_o        = r_count;
    assign exe_src_op_1_o = r_op1[r_head];
    assign exe_src_op_2_o = r_op2[r_head];
    assign exe_pc_o       = r_pc[r_head];
    assign exe_imm_o      = r_imm[r_head];
    assign exe_rrf_tag_o  = r_tag[r_head];
    assign exe_dst_val_o  = r_dst_val[r_head];

    generate
        for (genvar i = 0; i < ENT_NUM; i++) begin : g_ent
            logic [DATA_LEN:0] w_hit1;
            logic [DATA_LEN:0] w_hit2;
            assign w_hit1 = fwd_lookup(r_op1[i][RRF_SEL-1:0], fwd_valid_i, fwd_dst_i, fwd_result_i);
            assign w_hit2 = fwd_lookup(r_op2[i][RRF_SEL-1:0], fwd_valid_i, fwd_dst_i, fwd_result_i);
            assign w_cap1[i]      = r_busy[i] & ~r_v1[i] & w_hit1[DATA_LEN];
            assign w_cap2[i]      = r_busy[i] & ~r_v2[i] & w_hit2[DATA_LEN];
            assign w_cap1_data[i] = w_hit1[DATA_LEN-1:0];
            assign w_cap2_data[i] = w_hit2[DATA_LEN-1:0];
            assign ready_vector_o[i] = r_busy[i] & r_v1[i] & r_v2[i];
        end
    endgenerate

    // Dispatch operand order: slot1/op1, slot1/op2, slot2/op1, slot2/op2.
    assign w_in_op[0] = write_src_op_1_1_i;
    assign w_in_op[1] = write_src_op_1_2_i;
    assign w_in_op[2] = write_src_op_2_1_i;
    assign w_in_op[3] = write_src_op_2_2_i;
    assign w_in_v     = {write_valid_2_2_i, write_valid_2_1_i, write_valid_1_2_i, write_valid_1_1_i};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_disp_op
`ifdef RS_LDST_DISPATCH_BYPASS_EN
            logic [DATA_LEN:0] w_hit;
            assign w_hit       = fwd_lookup(w_in_op[j][RRF_SEL-1:0], fwd_valid_i, fwd_dst_i, fwd_result_i);
            assign w_new_v[j]  = w_in_v[j] | w_hit[DATA_LEN];
            assign w_new_op[j] = (!w_in_v[j] && w_hit[DATA_LEN]) ? w_hit[DATA_LEN-1:0] : w_in_op[j];
`else
            assign w_new_v[j]  = w_in_v[j];
            assign w_new_op[j] = w_in_op[j];
`endif
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_busy    <= '0;
            r_v1      <= '0;
            r_v2      <= '0;
            r_dst_val <= '0;
            for (int i = 0; i < ENT_NUM; i++) begin
                r_op1[i] <= '0;
                r_op2[i] <= '0;
                r_pc[i]  <= '0;
                r_imm[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
        end else begin
            for (int i = 0; i < ENT_NUM; i++) begin
                if (w_cap1[i]) begin
                    r_op1[i] <= w_cap1_data[i];
                    r_v1[i]  <= 1'b1;
                end
                if (w_cap2[i]) begin
                    r_op2[i] <= w_cap2_data[i];
                    r_v2[i]  <= 1'b1;
                end
            end
            if (w_fire)
                r_busy[r_head] <= 1'b0;
            // Dispatch targets are always free slots, so these never collide with capture or issue.
            if (w_we1) begin
                r_busy[r_tail]    <= 1'b1;
                r_op1[r_tail]     <= w_new_op[0];
                r_v1[r_tail]      <= w_new_v[0];
                r_op2[r_tail]     <= w_new_op[1];
                r_v2[r_tail]      <= w_new_v[1];
                r_pc[r_tail]      <= write_pc_1_i;
                r_imm[r_tail]     <= write_imm_1_i;
                r_tag[r_tail]     <= write_rrf_tag_1_i;
                r_dst_val[r_tail] <= write_dst_val_1_i;
            end
            if (w_we2) begin
                r_busy[w_idx2]    <= 1'b1;
                r_op1[w_idx2]     <= w_new_op[2];
                r_v1[w_idx2]      <= w_new_v[2];
                r_op2[w_idx2]     <= w_new_op[3];
                r_v2[w_idx2]      <= w_new_v[3];
                r_pc[w_idx2]      <= write_pc_2_i;
                r_imm[w_idx2]     <= write_imm_2_i;
                r_tag[w_idx2]     <= write_rrf_tag_2_i;
                r_dst_val[w_idx2] <= write_dst_val_2_i;
            end
            r_head  <= r_head + ENT_SEL'(w_fire);
            r_tail  <= r_tail + ENT_SEL'(w_n_disp);
            r_count <= r_count + (ENT_SEL+1)'(w_n_disp) - (ENT_SEL+1)'(w_fire);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i)
            assert (w_alloc_ok || !(we_1_i || we_2_i));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_ldst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_ldst_queue
// Purpose  : Directed scoreboard bench for rs_ldst_queue (issue order and data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_ldst_queue;

    localparam int ENT_NUM  = 8;
    localparam int ENT_SEL  = 3;
    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam int RRF_SEL  = 6;
    localparam int FWD_NUM  = 5;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                        reset_i, flush_i, we_1_i, we_2_i;
    logic [ADDR_LEN-1:0]         write_pc_1_i, write_pc_2_i;
    logic [DATA_LEN-1:0]         write_src_op_1_1_i, write_src_op_1_2_i;
    logic [DATA_LEN-1:0]         write_src_op_2_1_i, write_src_op_2_2_i;
    logic                        write_valid_1_1_i, write_valid_1_2_i;
    logic                        write_valid_2_1_i, write_valid_2_2_i;
    logic [DATA_LEN-1:0]         write_imm_1_i, write_imm_2_i;
    logic [RRF_SEL-1:0]          write_rrf_tag_1_i, write_rrf_tag_2_i;
    logic                        write_dst_val_1_i, write_dst_val_2_i;
    logic [FWD_NUM*DATA_LEN-1:0] fwd_result_i;
    logic [FWD_NUM*RRF_SEL-1:0]  fwd_dst_i;
    logic [FWD_NUM-1:0]          fwd_valid_i;
    logic                        issue_ready_i;
    logic                        alloc_ok_o;
    logic [ENT_SEL:0]            count_o;
    logic                        issue_valid_o;
    logic [DATA_LEN-1:0]         exe_src_op_1_o, exe_src_op_2_o, exe_imm_o;
    logic [ADDR_LEN-1:0]         exe_pc_o;
    logic [RRF_SEL-1:0]          exe_rrf_tag_o;
    logic                        exe_dst_val_o;
    logic [ENT_NUM-1:0]          ready_vector_o;

    rs_ldst_queue #(
        .ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .DATA_LEN(DATA_LEN),
        .ADDR_LEN(ADDR_LEN), .RRF_SEL(RRF_SEL), .FWD_NUM(FWD_NUM)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .we_1_i(we_1_i), .we_2_i(we_2_i),
        .write_pc_1_i(write_pc_1_i), .write_pc_2_i(write_pc_2_i),
        .write_src_op_1_1_i(write_src_op_1_1_i), .write_src_op_1_2_i(write_src_op_1_2_i),
        .write_src_op_2_1_i(write_src_op_2_1_i), .write_src_op_2_2_i(write_src_op_2_2_i),
        .write_valid_1_1_i(write_valid_1_1_i), .write_valid_1_2_i(write_valid_1_2_i),
        .write_valid_2_1_i(write_valid_2_1_i), .write_valid_2_2_i(write_valid_2_2_i),
        .write_imm_1_i(write_imm_1_i), .write_imm_2_i(write_imm_2_i),
        .write_rrf_tag_1_i(write_rrf_tag_1_i), .write_rrf_tag_2_i(write_rrf_tag_2_i),
        .write_dst_val_1_i(write_dst_val_1_i), .write_dst_val_2_i(write_dst_val_2_i),
        .fwd_result_i(fwd_result_i), .fwd_dst_i(fwd_dst_i), .fwd_valid_i(fwd_valid_i),
        .issue_ready_i(issue_ready_i),
        .alloc_ok_o(alloc_ok_o), .count_o(count_o), .issue_valid_o(issue_valid_o),
        .exe_src_op_1_o(exe_src_op_1_o), .exe_src_op_2_o(exe_src_op_2_o),
        .exe_pc_o(exe_pc_o), .exe_imm_o(exe_imm_o), .exe_rrf_tag_o(exe_rrf_tag_o),
        .exe_dst_val_o(exe_dst_val_o), .ready_vector_o(ready_vector_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [5:0]  tag;
        logic        dv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Each accepted issue must match the oldest outstanding expected entry.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!reset_i && !flush_i && issue_valid_o && issue_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue_unexpected: got issue of pc %0h expected no issue", exe_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("issue_pc",  exe_pc_o,       e.pc);
                check("issue_op1", exe_src_op_1_o, e.op1);
                check("issue_op2", exe_src_op_2_o, e.op2);
                check("issue_imm", exe_imm_o,      e.imm);
                check("issue_tag", exe_rrf_tag_o,  e.tag);
                check("issue_dv",  exe_dst_val_o,  e.dv);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        we_1_i      = 1'b0;
        we_2_i      = 1'b0;
        flush_i     = 1'b0;
        fwd_valid_i = '0;
    endtask

    task automatic set_slot(input int s, input logic [31:0] pc, input logic [31:0] op1, input logic v1,
                            input logic [31:0] op2, input logic v2, input logic [31:0] imm,
                            input logic [5:0] tag, input logic dv);
        if (s == 1) begin
            write_pc_1_i = pc; write_src_op_1_1_i = op1; write_valid_1_1_i = v1;
            write_src_op_1_2_i = op2; write_valid_1_2_i = v2; write_imm_1_i = imm;
            write_rrf_tag_1_i = tag; write_dst_val_1_i = dv; we_1_i = 1'b1;
        end else begin
            write_pc_2_i = pc; write_src_op_2_1_i = op1; write_valid_2_1_i = v1;
            write_src_op_2_2_i = op2; write_valid_2_2_i = v2; write_imm_2_i = imm;
            write_rrf_tag_2_i = tag; write_dst_val_2_i = dv; we_2_i = 1'b1;
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                            input logic [31:0] imm, input logic [5:0] tag, input logic dv);
        exp_t e;
        e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm; e.tag = tag; e.dv = dv;
        exp_q.push_back(e);
    endtask

    // Fully-ready entry number n in dispatch slot s.
    task automatic disp_one(input int s, input int n, input bit expect_it);
        logic [31:0] pc, op1, op2, imm;
        logic [5:0]  tag;
        logic        dv;
        pc  = 32'(32'h1000 + 4 * n);
        op1 = 32'(32'h100 + n);
        op2 = 32'(32'h200 + n);
        imm = 32'(n);
        tag = 6'(n);
        dv  = imm[0];
        set_slot(s, pc, op1, 1'b1, op2, 1'b1, imm, tag, dv);
        if (expect_it)
            push_exp(pc, op1, op2, imm, tag, dv);
    endtask

    task automatic disp_pair(input int n, input bit expect_it);
        disp_one(1, n, expect_it);
        disp_one(2, n + 1, expect_it);
    endtask

    task automatic set_fwd(input int k, input logic [5:0] tag, input logic [31:0] data);
        fwd_valid_i[k]             = 1'b1;
        fwd_dst_i[k*RRF_SEL +: RRF_SEL]   = tag;
        fwd_result_i[k*DATA_LEN +: DATA_LEN] = data;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        issue_ready_i = 1'b1;
        while (count_o != 0 && n < 40) begin
            step();
            n++;
        end
        check(name, count_o, 0);
        issue_ready_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        issue_ready_i = 1'b0;
        fwd_result_i = '0;
        fwd_dst_i = '0;
        idle_inputs();
        set_slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        repeat (3) step();
        reset_i = 1'b0;

        check("rst_alloc_ok", alloc_ok_o, 1);
        check("rst_count", count_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_ready_vector", ready_vector_o, 0);
        check("rst_exe_op1", exe_src_op_1_o, 0);
        check("rst_exe_pc", exe_pc_o, 0);

        // Single ready dispatch issues the next cycle
        set_slot(1, 32'h80, 32'h10, 1, 32'h20, 1, 32'h4, 6'd1, 1);
        push_exp(32'h80, 32'h10, 32'h20, 32'h4, 6'd1, 1);
        step(); idle_inputs();
        check("t1_issue_valid", issue_valid_o, 1);
        check("t1_exe_op1", exe_src_op_1_o, 32'h10);
        check("t1_exe_pc", exe_pc_o, 32'h80);
        check("t1_count", count_o, 1);
        drain("t1_drain_count");
        check("t1_valid_after", issue_valid_o, 0);

        // Forward capture; bus 3 beats bus 4 with the same tag
        set_slot(1, 32'h84, 32'd5, 0, 32'h33, 1, 32'h8, 6'd2, 0);
        push_exp(32'h84, 32'hDEAD, 32'h33, 32'h8, 6'd2, 0);
        step(); idle_inputs();
        check("t2_wait_valid", issue_valid_o, 0);
        set_fwd(4, 6'd5, 32'hBEEF);
        set_fwd(3, 6'd5, 32'hDEAD);
        set_fwd(2, 6'd6, 32'h1111);
        step(); idle_inputs();
        check("t2_fwd_valid", issue_valid_o, 1);
        check("t2_fwd_op1", exe_src_op_1_o, 32'hDEAD);
        drain("t2_drain_count");

        // In-order issue: head (slot 2) waits on tag 7, younger (slot 3) is ready
        set_slot(1, 32'h90, 32'd7, 0, 32'h2, 1, 32'h0, 6'd3, 1);
        set_slot(2, 32'h94, 32'hA, 1, 32'hB, 1, 32'h0, 6'd4, 1);
        push_exp(32'h90, 32'h77, 32'h2, 32'h0, 6'd3, 1);
        push_exp(32'h94, 32'hA, 32'hB, 32'h0, 6'd4, 1);
        step(); idle_inputs();
        issue_ready_i = 1'b1;
        check("t3_hold_valid", issue_valid_o, 0);
        check("t3_ready_vec", ready_vector_o, 8'h08);
        check("t3_count", count_o, 2);
        step();
        check("t3_still_hold", issue_valid_o, 0);
        set_fwd(1, 6'd7, 32'h77);
        step(); idle_inputs();
        check("t3_head_valid", issue_valid_o, 1);
        check("t3_head_op1", exe_src_op_1_o, 32'h77);
        check("t3_ready_vec2", ready_vector_o, 8'h0C);
        step();
        check("t3_young_op1", exe_src_op_1_o, 32'hA);
        check("t3_count_one", count_o, 1);
        step();
        check("t3_count_zero", count_o, 0);
        issue_ready_i = 1'b0;

        // Fill from head=tail=4; third pair wraps into slots 0 and 1
        for (int i = 0; i < 3; i++) begin
            disp_pair(2 * i, 1'b1);
            step();
        end
        idle_inputs();
        check("t4_count6", count_o, 6);
        check("t4_alloc6", alloc_ok_o, 1);
        check("t4_ready_wrap", ready_vector_o, 8'hF3);
        disp_pair(6, 1'b1);
        step(); idle_inputs();
        check("t4_count_full", count_o, 8);
        check("t4_alloc_full", alloc_ok_o, 0);
        check("t4_ready_full", ready_vector_o, 8'hFF);
        issue_ready_i = 1'b1;
        step();
        check("t4_count7", count_o, 7);
        check("t4_alloc7", alloc_ok_o, 0);
        step();
        check("t4_count6b", count_o, 6);
        check("t4_alloc6b", alloc_ok_o, 1);
        disp_pair(8, 1'b1);
        step(); idle_inputs();
        check("t4_fire_dual_count", count_o, 7);
        check("t4_fire_dual_alloc", alloc_ok_o, 0);
        drain("t4_drain_count");

        // Four entries at head=6, then flush with concurrent dispatch and fire
        disp_pair(20, 1'b0);
        step();
        disp_pair(22, 1'b0);
        step(); idle_inputs();
        check("t5_count4", count_o, 4);
        check("t5_ready_vec", ready_vector_o, 8'hC3);
        flush_i = 1'b1;
        disp_one(1, 24, 1'b0);
        issue_ready_i = 1'b1;
        step(); idle_inputs();
        issue_ready_i = 1'b0;
        check("t5_flush_count", count_o, 0);
        check("t5_flush_valid", issue_valid_o, 0);
        check("t5_flush_ready_vec", ready_vector_o, 0);
        check("t5_flush_alloc", alloc_ok_o, 1);
        disp_one(1, 30, 1'b1);
        step(); idle_inputs();
        check("t5_restart_slot0", ready_vector_o, 8'h01);
        drain("t5_drain_count");

        // Forward broadcast in the dispatch cycle
        set_slot(1, 32'hB0, 32'h1, 1, 32'd9, 0, 32'hC, 6'd9, 1);
        set_fwd(0, 6'd9, 32'h42);
        push_exp(32'hB0, 32'h1, 32'h42, 32'hC, 6'd9, 1);
        step(); idle_inputs();
`ifdef RS_LDST_DISPATCH_BYPASS_EN
        check("t6_bypass_valid", issue_valid_o, 1);
        check("t6_bypass_op2", exe_src_op_2_o, 32'h42);
`else
        check("t6_nobypass_valid", issue_valid_o, 0);
        set_fwd(0, 6'd9, 32'h42);
        step(); idle_inputs();
        check("t6_late_valid", issue_valid_o, 1);
        check("t6_late_op2", exe_src_op_2_o, 32'h42);
`endif
        drain("t6_drain_count");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_ldst_queue.md
Name: rs_ldst_queue

Overview:
- Parametrised successor to the 4-entry load/store reservation station.
- Entries form a circular, age-ordered queue. Only the oldest entry may issue, which enforces program-order memory access.
- Accepts up to two dispatches per cycle and captures operands from FWD_NUM result buses.
- Issues to the LSU pipeline through a valid/ready handshake, and supports a full flush on misprediction.

Parameters:
- ENT_NUM, 8, queue depth (power of two, >= 4)
- ENT_SEL, 3, log2(ENT_NUM)
- DATA_LEN, 32, operand/immediate width
- ADDR_LEN, 32, PC width
- RRF_SEL, 6, rename tag width
- FWD_NUM, 5, number of result forwarding buses

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  kill all entries (mispredict)
- we_1_i, we_2_i  in  1 each  dispatch slot enables
- write_pc_{1,2}_i  in  ADDR_LEN  PC
- write_src_op_{1,2}_{1,2}_i  in  DATA_LEN  operand value, or RRF tag in low RRF_SEL bits when not valid
- write_valid_{1,2}_{1,2}_i  in  1  operand valid
- write_imm_{1,2}_i  in  DATA_LEN  immediate
- write_rrf_tag_{1,2}_i  in  RRF_SEL  destination tag
- write_dst_val_{1,2}_i  in  1  destination written
- fwd_result_i  in  FWD_NUM*DATA_LEN  forwarded results, bus k at [k*DATA_LEN +: DATA_LEN]
- fwd_dst_i  in  FWD_NUM*RRF_SEL  forwarded tags
- fwd_valid_i  in  FWD_NUM  bus valid
- issue_ready_i  in  1  LSU accepts
- alloc_ok_o  out  1  at least two free entries
- count_o  out  ENT_SEL+1  occupied entries
- issue_valid_o  out  1  head occupied and both operands valid
- exe_src_op_1_o, exe_src_op_2_o  out  DATA_LEN  head operands
- exe_pc_o  out  ADDR_LEN  head PC
- exe_imm_o  out  DATA_LEN  head immediate
- exe_rrf_tag_o  out  RRF_SEL  head destination tag
- exe_dst_val_o  out  1  head destination valid
- ready_vector_o  out  ENT_NUM  per-entry operands-ready AND busy, indexed by physical slot

Behaviour:
- State:
  - head and tail pointers, ENT_SEL bits each, wrapping modulo ENT_NUM.
  - count, ENT_SEL+1 bits.
  - Per entry: busy, op1/op2 plus their valid bits, pc, imm, tag, dst_val.
- Reset (and flush_i, same edge):
  - head = tail = count = 0; all busy = 0.
  - Outputs: alloc_ok_o = 1, count_o = 0, issue_valid_o = 0, ready_vector_o = 0.
  - Data outputs are don't-care but drive 0 after reset.
  - reset_i has priority over flush_i; flush_i has priority over dispatch and issue in the same cycle.
- alloc_ok_o = (ENT_NUM - count >= 2), combinational from count.
- Dispatch:
  - Dispatch while alloc_ok_o = 0 is dropped silently. The bench must never do this; an assertion fires.
  - If both we_1_i and we_2_i are set: slot 1 is written at tail, slot 2 at tail+1, tail += 2.
  - If only one is set: it is written at tail, tail += 1.
  - The entry becomes busy at the next edge.
- Operand capture:
  - Each cycle, for every busy entry with an invalid operand, compare the operand's tag (low RRF_SEL bits) against each valid fwd_dst_i.
  - On a match, latch the data and set valid at the next edge.
  - If several buses match, the lowest bus index wins.
- Issue:
  - issue_valid_o = busy[head] AND op1 valid AND op2 valid. All exe_* outputs come combinationally from the head entry.
  - Fire = issue_valid_o AND issue_ready_i. On fire: busy[head] cleared, head += 1.
  - Entries behind the head never issue, even when ready.
- Count: count_next = count + (number of dispatches) - fire. Simultaneous fire and double dispatch with count = ENT_NUM-2 is legal; the result is ENT_NUM-1.
- Latency:
  - Dispatch with both operands valid: issue_valid_o is high the cycle after the dispatch edge.
  - Forward match: operand becomes valid the cycle after the forward edge.
- Wrap-around: pointers and the 2-wide allocation wrap; for example, tail = ENT_NUM-1 with two dispatches writes slots ENT_NUM-1 and 0.

Optional Feature:
- Macro: RS_LDST_DISPATCH_BYPASS_EN.
- Defined: forwarding buses are also compared against incoming dispatch operands that are invalid. On a match, the forwarded data is written and the operand is valid in the dispatch edge itself, so no forward is lost when a result is broadcast in the dispatch cycle.
- Undefined: dispatched operands are stored exactly as presented. A forward in the same cycle as dispatch is missed, and upstream must guarantee that does not happen.

Test Plan:
- Reset, then dispatch slot 1 only (op1 = 0x10, op2 = 0x20, both valid, pc = 0x80) -> next cycle issue_valid_o = 1, exe_src_op_1_o = 0x10, exe_pc_o = 0x80; with issue_ready_i = 1 -> count_o returns 0.
- Dispatch an entry with op1 invalid (tag 5), then drive fwd_valid_i[3] = 1, fwd_dst_i bus 3 = 5, result 0xDEAD -> issue_valid_o rises the following cycle with exe_src_op_1_o = 0xDEAD.
- Ordering: head waiting on tag 7, younger entry fully ready -> issue_valid_o stays 0 and ready_vector_o shows only the younger slot; after tag 7 is forwarded, the head issues first, then the younger entry.
- Fill to ENT_NUM-2 -> alloc_ok_o = 1; dispatch two -> count_o = ENT_NUM, alloc_ok_o = 0; fire one plus dispatch none -> alloc_ok_o stays 0 until count_o <= ENT_NUM-2; verify tail wrap writes slot 0.
- Four entries queued with head = 6, then flush_i concurrent with we_1_i and fire -> next cycle count_o = 0, issue_valid_o = 0, ready_vector_o = 0.
- Bypass enabled: dispatch op2 invalid (tag 9) while fwd bus 0 carries tag 9, data 0x42 -> issue_valid_o = 1 next cycle with exe_src_op_2_o = 0x42. Bypass disabled: issue_valid_o stays 0.
